// File: rtl/mips_muldiv_unit_if.sv
// mips_muldiv_unit_if: issue/result bundle between the pipeline and the mul/div unit.
// master = pipeline side (drives requests); slave = mul/div unit (drives status, hi, lo).
interface mips_muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [5:0]        fncode;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output in_valid, fncode, op_a, op_b,
        input  in_ready, busy, done, hi, lo
    );

    modport slave (
        input  in_valid, fncode, op_a, op_b,
        output in_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO.
// MTHI/MTLO write in one cycle; MFHI/MFLO and unknown codes do nothing.
// Ports: clk, rst_n (async active-low), bus (slave modport):
//   in_valid/in_ready/fncode/op_a/op_b in, busy/done/hi/lo out.
// Option: define MULDIV_FAST_MUL_EN for a single-cycle multiply (IDLE -> FIX).
module mips_muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(DATA_W);
    localparam int PW = 2 * DATA_W;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic              r_done;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    // r_ph: product high / partial remainder; r_pl: multiplier / quotient
    logic [DATA_W-1:0] r_ph;
    logic [DATA_W-1:0] r_pl;
    logic [DATA_W-1:0] r_m;
    logic [DATA_W-1:0] r_a_orig;
    logic              r_is_div;
    logic              r_dbz;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_idle;
    logic              w_accept;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_mthi;
    logic              w_mtlo;
    logic [DATA_W-1:0] w_abs_a;
    logic [DATA_W-1:0] w_abs_b;
    logic              w_neg_q;
    logic              w_neg_r;
    logic [DATA_W:0]   w_mul_sum;
    logic [DATA_W+1:0] w_div_shift;
    logic [DATA_W+1:0] w_div_diff;
    logic              w_div_ok;
    logic [PW-1:0]     w_prod;
    logic [PW-1:0]     w_prod_fix;
    logic [DATA_W-1:0] w_quo_fix;
    logic [DATA_W-1:0] w_rem_fix;
`ifdef MULDIV_FAST_MUL_EN
    logic [PW-1:0]     w_fast_prod;
`endif

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = bus.in_valid && w_idle;

    assign w_is_mul = (bus.fncode == FUNCT_MULT) || (bus.fncode == FUNCT_MULTU);
    assign w_is_div = (bus.fncode == FUNCT_DIV)  || (bus.fncode == FUNCT_DIVU);
    assign w_signed = (bus.fncode == FUNCT_MULT) || (bus.fncode == FUNCT_DIV);
    assign w_mthi   = (bus.fncode == FUNCT_MTHI);
    assign w_mtlo   = (bus.fncode == FUNCT_MTLO);

    // Negating 0x80000000 yields itself, which is the correct unsigned magnitude.
    assign w_abs_a = (w_signed && bus.op_a[DATA_W-1]) ? -bus.op_a : bus.op_a;
    assign w_abs_b = (w_signed && bus.op_b[DATA_W-1]) ? -bus.op_b : bus.op_b;
    assign w_neg_q = w_signed && (bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1]);
    assign w_neg_r = w_signed && bus.op_a[DATA_W-1];

    // Shift-add step: add multiplicand when multiplier LSB set, then shift right.
    assign w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_m} : '0);

    // Restoring step: extra top bit of the difference acts as the borrow.
    assign w_div_shift = {1'b0, r_ph, r_pl[DATA_W-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_m};
    assign w_div_ok    = ~w_div_diff[DATA_W+1];

    assign w_prod     = {r_ph, r_pl};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg_q ? -r_pl : r_pl;
    assign w_rem_fix  = r_neg_r ? -r_ph : r_ph;

`ifdef MULDIV_FAST_MUL_EN
    assign w_fast_prod = PW'(w_abs_a) * PW'(w_abs_b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_div) begin
                    w_state_nxt = S_RUN;
                end
                if (w_accept && w_is_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_state_nxt = S_FIX;
`else
                    w_state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_ph     <= '0;
            r_pl     <= '0;
            r_m      <= '0;
            r_a_orig <= '0;
            r_is_div <= 1'b0;
            r_dbz    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        unique case (1'b1)
                            w_mthi: r_hi <= bus.op_a;
                            w_mtlo: r_lo <= bus.op_a;
                            w_is_mul, w_is_div: begin
                                r_cnt    <= CW'(DATA_W - 1);
                                r_is_div <= w_is_div;
                                r_dbz    <= w_is_div && (bus.op_b == '0);
                                r_neg_q  <= w_neg_q;
                                r_neg_r  <= w_neg_r;
                                r_a_orig <= bus.op_a;
                                r_ph     <= '0;
                                r_m      <= w_is_div ? w_abs_b : w_abs_a;
                                r_pl     <= w_is_div ? w_abs_a : w_abs_b;
`ifdef MULDIV_FAST_MUL_EN
                                if (w_is_mul) begin
                                    {r_ph, r_pl} <= w_fast_prod;
                                end
`endif
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_ph <= w_div_ok ? w_div_diff[DATA_W-1:0]
                                         : w_div_shift[DATA_W-1:0];
                        r_pl <= {r_pl[DATA_W-2:0], w_div_ok};
                    end else begin
                        r_ph <= w_mul_sum[DATA_W:1];
                        r_pl <= {w_mul_sum[0], r_pl[DATA_W-1:1]};
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_dbz ? '1 : w_quo_fix;
                        r_hi <= r_dbz ? r_a_orig : w_rem_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready = w_idle;
    assign bus.busy     = ~w_idle;
    assign bus.done     = r_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule
